// File: rtl/crc16_frame_tx_if.sv
// Stream bundle for crc16_frame_tx: payload-in (s_*) and framed-out (m_*) handshakes.
// master = packet source / serializer side, slave = the framer itself.
interface crc16_frame_tx_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_last;
   logic       m_ready;

   modport master (
      output s_data, s_valid, s_last, m_ready,
      input  s_ready, m_data, m_valid, m_last
   );

   modport slave (
      input  s_data, s_valid, s_last, m_ready,
      output s_ready, m_data, m_valid, m_last
   );
endinterface

// File: rtl/crc16_frame_tx.sv
// CRC-CCITT (0x1021, init 0xFFFF) transmit framer: passes payload through, appends CRC MSB first.
// Optional frame/error statistics counters are built when CRC16_FRAME_STATS_EN is defined.

module crc16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        clk_en,
   input  logic [7:0]  data,
   output logic [15:0] crc
);
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n)       crc <= 16'hFFFF;
      else if (!clr)    crc <= 16'hFFFF;
      else if (clk_en)  crc <= crc_byte(crc, data);
   end
endmodule

module crc16_frame_tx #(
   parameter int MAX_LEN = 4095
) (
   input  logic             clk,
   input  logic             reset,
   crc16_frame_tx_if.slave  bus,
   output logic             busy,
   output logic             frame_done,
   output logic             len_err
`ifdef CRC16_FRAME_STATS_EN
   ,
   output logic [15:0]      frame_cnt,
   output logic [7:0]       err_cnt
`endif
);
   typedef enum logic [1:0] {IDLE, PAYLOAD, CRC_HI, CRC_LO} state_t;

   state_t      state;
   logic [11:0] len;
   logic [15:0] crc;
   logic        hs_in;
   logic        s_ready;
   logic        m_valid;
   logic        m_last;
   logic [7:0]  m_data;

   assign hs_in = (state == PAYLOAD) && bus.s_valid && bus.m_ready;
   assign busy  = (state != IDLE);

   // Engine is cleared throughout IDLE so every frame starts from 0xFFFF.
   crc16 u_crc (
      .clk    (clk),
      .rst_n  (1'b1),
      .clr    (state != IDLE),
      .clk_en (hs_in),
      .data   (bus.s_data),
      .crc    (crc)
   );

   always_comb begin
      s_ready = 1'b0;
      m_valid = 1'b0;
      m_last  = 1'b0;
      m_data  = 8'h00;
      case (state)
         PAYLOAD: begin
            s_ready = bus.m_ready;
            m_valid = bus.s_valid;
            m_data  = bus.s_valid ? bus.s_data : 8'h00;
         end
         CRC_HI: begin
            m_valid = 1'b1;
            m_data  = crc[15:8];
         end
         CRC_LO: begin
            m_valid = 1'b1;
            m_last  = 1'b1;
            m_data  = crc[7:0];
         end
         default: ;
      endcase
   end

   assign bus.s_ready = s_ready;
   assign bus.m_valid = m_valid;
   assign bus.m_last  = m_last;
   assign bus.m_data  = m_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         len        <= 12'd0;
         frame_done <= 1'b0;
         len_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         len_err    <= 1'b0;
         case (state)
            IDLE: begin
               len <= 12'd0;
               if (bus.s_valid) state <= PAYLOAD;
            end
            PAYLOAD: begin
               if (hs_in) begin
                  len <= len + 12'd1;
                  if (bus.s_last) begin
                     state <= CRC_HI;
                  end else if (len == 12'(MAX_LEN - 1)) begin
                     // Forced cut: remaining source bytes start the next frame.
                     state   <= CRC_HI;
                     len_err <= 1'b1;
                  end
               end
            end
            CRC_HI: begin
               if (bus.m_ready) state <= CRC_LO;
            end
            CRC_LO: begin
               if (bus.m_ready) begin
                  state      <= IDLE;
                  len        <= 12'd0;
                  frame_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CRC16_FRAME_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= 16'd0;
         err_cnt   <= 8'd0;
      end else begin
         if (frame_done)                 frame_cnt <= frame_cnt + 16'd1;
         if (len_err && err_cnt != 8'hFF) err_cnt  <= err_cnt + 8'd1;
      end
   end
`endif
endmodule

// File: doc/crc16_frame_tx.md
Name: crc16_frame_tx

Overview:
- Transmit-side framer and sequencer for the byte-wide CRC-CCITT engine `crc16`.
  - Poly 0x1021, init 0xFFFF, no reflection, XorOut 0x0000.
- Accepts a payload byte stream with valid/ready and passes each byte through unchanged while clocking it into the engine.
- Appends the 16-bit CRC, MSB byte first, then signals frame completion.
- Sits between the packet source and the serializer/UART transmit path.

Parameters:
- MAX_LEN, 4095, maximum payload bytes per frame (CRC-CCITT detection limit); range 1..4095.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- s_data  in  8  payload byte from the source.
- s_valid  in  1  s_data valid.
- s_last  in  1  qualifies the final payload byte of a frame.
- s_ready  out  1  block accepts s_data this cycle.
- m_data  out  8  output byte: payload, then CRC[15:8], then CRC[7:0].
- m_valid  out  1  m_data valid.
- m_last  out  1  asserted with the CRC[7:0] byte only.
- m_ready  in  1  downstream accepts m_data.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse, the cycle after the CRC[7:0] handshake.
- len_err  out  1  one-cycle pulse when a frame is force-terminated at MAX_LEN.

Behaviour:
- Reset: state IDLE; len counter 0.
  - s_ready, m_valid, m_last, busy, frame_done and len_err are all 0.
  - m_data is 0x00 when m_valid=0.
- Engine hookup: one `crc16` instance.
  - Its own reset input is tied inactive (high).
  - clr (active-low) is driven low in every IDLE cycle, so the engine register reads 0xFFFF on PAYLOAD entry.
  - clk_en = s_valid & s_ready in PAYLOAD; otherwise 0.
- FSM states: IDLE, PAYLOAD, CRC_HI, CRC_LO.
- IDLE:
  - s_ready=0, m_valid=0.
  - If s_valid=1, go to PAYLOAD next cycle. This costs one bubble cycle per frame; the byte is not consumed in IDLE.
- PAYLOAD:
  - Combinational pass-through: m_data=s_data, m_valid=s_valid, s_ready=m_ready, m_last=0.
  - On handshake (s_valid & m_ready): engine updates, len increments.
  - If s_last=1 on the handshake, go to CRC_HI.
  - If len reaches MAX_LEN on the handshake with s_last=0:
    - force-terminate, go to CRC_HI, pulse len_err the next cycle;
    - the source's later bytes belong to the next frame.
- CRC_HI:
  - s_ready=0, m_valid=1, m_data=crc[15:8].
  - On m_ready, go to CRC_LO. The engine holds its value because clk_en=0.
- CRC_LO:
  - m_valid=1, m_data=crc[7:0], m_last=1.
  - On m_ready: go to IDLE, clear len, pulse frame_done the next cycle.
- Backpressure: m_valid, once asserted in CRC_HI/CRC_LO, stays high with stable m_data until m_ready.
- Payload latency is zero cycles, combinational.
- Simultaneous s_last with len==MAX_LEN is a normal termination; len_err stays 0.
- Reset mid-frame (any state): next cycle is IDLE with all outputs at reset values, and no partial CRC is emitted. The following frame's CRC is correct because IDLE re-clears the engine.
- len is a 12-bit counter; it never wraps because termination occurs at MAX_LEN.

Optional Feature:
- Macro: CRC16_FRAME_STATS_EN.
- With the macro defined, the block adds:
  - frame_cnt  out 16: increments on every frame_done and wraps at 0xFFFF->0.
  - err_cnt  out 8: increments on every len_err and saturates at 0xFF.
  - Both counters reset to 0.
- Without the macro, both ports and their counters are absent. Core behaviour is identical in both builds.

Test Plan:
- Frame "123456789" (0x31..0x39, s_last on 0x39), m_ready=1: m_data sequence 31..39, 29, B1; m_last only on B1; frame_done pulse one cycle later.
- Single byte 0x00 with s_last: output 00, E1, F0; two frames back-to-back give identical CRCs, which proves the IDLE clear.
- "123456789" with m_ready toggling 1/0 every cycle: same output sequence; no byte is lost or duplicated; m_data is stable while m_valid=1 & m_ready=0.
- MAX_LEN=4, source sends 6 bytes 01 02 03 04 05 06 with s_last on 06:
  - 01..04 are followed by the CRC over those 4 bytes, and len_err pulses once;
  - 05 06 then form a second frame with its own CRC.
- reset asserted for 1 cycle while in CRC_HI: m_valid=0 and busy=0 the next cycle; no CRC_LO byte appears; next "123456789" frame yields 29 B1.
- With CRC16_FRAME_STATS_EN: 3 frames plus 1 forced termination give frame_cnt=4, err_cnt=1; reset returns both to 0.
